goldschmidt_post: RTL and testbench

Result post-processing stage directly downstream of the Goldschmidt divider datapath.
- Watches the divider controller's remainder-cycle strobe.
- Captures the final quotient and remainder sign, then applies a one-ulp correction.
- Normalizes to a hidden-one mantissa, rounds to nearest-even at OUT_WIDTH bits, and presents the result on a valid/ready interface to the consumer (exponent/pack logic).

---
 rtl/goldschmidt_pkg.sv | 21 ++
 rtl/gs_round_rne.sv | 42 ++++
 rtl/goldschmidt_post.sv | 115 +++++++++++
 tb/tb_goldschmidt_post.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/goldschmidt_pkg.sv
// rtl/goldschmidt_pkg.sv - shared types and constants for the Goldschmidt result path
package goldschmidt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    NORM    = 3'd2,
    ROUND   = 3'd3,
    HOLD    = 3'd4
  } gpost_state_t;

  localparam logic [1:0] EXP_M1 = 2'b11;
  localparam logic [1:0] EXP_0  = 2'b00;
  localparam logic [1:0] EXP_P1 = 2'b01;

  // Quotients are Q2.(w-2): the bit worth 1.0 sits just below the top bit.
  function automatic int gs_one_bit(input int w);
    return w - 2;
  endfunction

endpackage

// File: rtl/gs_round_rne.sv
// rtl/gs_round_rne.sv - round-to-nearest-even of a normalized Q2 value to OUT_WIDTH bits
module gs_round_rne
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH     = 30,
  parameter int OUT_WIDTH = 24
) (
  input  logic [WIDTH-1:0]     norm_i,
  input  logic [1:0]           exp_i,
  output logic [OUT_WIDTH-1:0] mant_o,
  output logic [1:0]           exp_o
);

  localparam int ONE = gs_one_bit(WIDTH);
  localparam int GB  = ONE - OUT_WIDTH;

  logic [OUT_WIDTH-1:0] field;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [OUT_WIDTH:0]   sum;
  logic                 unused_msb;

  // The integer bit above 1.0 is only meaningful for range errors, which bypass rounding.
  assign unused_msb = norm_i[WIDTH-1];

  assign field    = norm_i[ONE -: OUT_WIDTH];
  assign guard    = norm_i[GB];
  assign sticky   = |norm_i[GB-1:0];
  assign round_up = guard & (sticky | field[0]);
  assign sum      = {1'b0, field} + {{OUT_WIDTH{1'b0}}, round_up};

  always_comb begin
    mant_o = sum[OUT_WIDTH-1:0];
    exp_o  = exp_i;
    if (sum[OUT_WIDTH]) begin
      mant_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      exp_o  = exp_i + EXP_P1;
    end
  end

endmodule

// File: rtl/goldschmidt_post.sv
// rtl/goldschmidt_post.sv - quotient correction, normalization and rounding after the divider
module goldschmidt_post
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH     = 30,
  parameter int OUT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 div_rem,
  input  logic [WIDTH-1:0]     quotient,
  input  logic                 rem_sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] mantissa,
  output logic [1:0]           exp_adj,
  output logic                 range_err,
  output logic                 overrun
);

  localparam int ONE = gs_one_bit(WIDTH);

  gpost_state_t state_q, state_d;

  logic [WIDTH-1:0]     q_q;
  logic                 sign_q;
  logic [WIDTH-1:0]     norm_q, norm_d;
  logic [1:0]           nexp_q, nexp_d;
  logic                 nrange_q;
  logic [WIDTH-1:0]     qc;
  logic [OUT_WIDTH-1:0] mant_q, rnd_mant;
  logic [1:0]           exp_q, rnd_exp;
  logic                 range_q;
  logic                 overrun_q;
  logic                 drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_rem) state_d = CAPTURE;
      CAPTURE: state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = HOLD;
      HOLD:    if (out_ready) state_d = div_rem ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign drop = div_rem && ((state_q == CAPTURE) || (state_q == NORM) || (state_q == ROUND) ||
                            ((state_q == HOLD) && !out_ready));

  // A set remainder sign means the quotient overshot by one ulp.
  assign qc = sign_q ? (q_q - WIDTH'(1)) : q_q;

  always_comb begin
    norm_d = qc;
    nexp_d = EXP_0;
    if (!qc[WIDTH-1] && !qc[ONE]) begin
      norm_d = qc << 1;
      nexp_d = EXP_M1;
    end
  end

  gs_round_rne #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round (
    .norm_i (norm_q),
    .exp_i  (nexp_q),
    .mant_o (rnd_mant),
    .exp_o  (rnd_exp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q       <= '0;
      sign_q    <= 1'b0;
      norm_q    <= '0;
      nexp_q    <= EXP_0;
      nrange_q  <= 1'b0;
      mant_q    <= '0;
      exp_q     <= EXP_0;
      range_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (state_q == CAPTURE) begin
        q_q    <= quotient;
        sign_q <= rem_sign;
      end
      if (state_q == NORM) begin
        norm_q   <= norm_d;
        nexp_q   <= nexp_d;
        nrange_q <= qc[WIDTH-1];
      end
      if (state_q == ROUND) begin
        mant_q  <= nrange_q ? {OUT_WIDTH{1'b1}} : rnd_mant;
        exp_q   <= nrange_q ? EXP_0 : rnd_exp;
        range_q <= nrange_q;
      end
      if (drop) overrun_q <= 1'b1;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign mantissa  = mant_q;
  assign exp_adj   = exp_q;
  assign range_err = range_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_goldschmidt_post.sv
// tb/tb_goldschmidt_post.sv - scoreboard bench for goldschmidt_post
module tb_goldschmidt_post;

  typedef struct packed {
    logic [23:0] m;
    logic [1:0]  e;
    logic        r;
  } exp_t;

  typedef struct packed {
    logic [29:0] q;
    logic        s;
    logic [23:0] m;
    logic [1:0]  e;
    logic        r;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        div_rem = 1'b0;
  logic [29:0] quotient = '0;
  logic        rem_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] mantissa;
  logic [1:0]  exp_adj;
  logic        range_err;
  logic        overrun;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  goldschmidt_post #(.WIDTH(30), .OUT_WIDTH(24)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .div_rem   (div_rem),
    .quotient  (quotient),
    .rem_sign  (rem_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mantissa  (mantissa),
    .exp_adj   (exp_adj),
    .range_err (range_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [29:0] q, input logic s);
    exp_t        r;
    logic [29:0] v;
    int unsigned f, low;
    v   = s ? q - 30'd1 : q;
    r.e = 2'b00;
    r.r = 1'b0;
    if (v >= 30'h2000_0000) begin
      r.m = 24'hFF_FFFF;
      r.r = 1'b1;
      return r;
    end
    if (v < 30'h1000_0000) begin
      v   = v * 2;
      r.e = 2'b11;
    end
    f   = 32'(v) / 32;
    low = 32'(v) % 32;
    if (low > 16 || (low == 16 && (f % 2) == 1)) f = f + 1;
    if (f == 32'h0100_0000) begin
      f   = 32'h0080_0000;
      r.e = (r.e == 2'b11) ? 2'b00 : 2'b01;
    end
    r.m = f[23:0];
    return r;
  endfunction

  task automatic wait_result(input string tag);
    int   lat;
    bit   got;
    exp_t e;
    lat = 0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (out_valid) got = 1;
    end
    check_eq({tag, "_latency"}, lat, 3);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_mant"}, mantissa, e.m);
      check_eq({tag, "_exp"}, exp_adj, e.e);
      check_eq({tag, "_rerr"}, range_err, e.r);
    end
  endtask

  task automatic issue(input logic [29:0] q, input logic s, input exp_t e, input string tag);
    @(negedge clk);
    div_rem  = 1'b1;
    quotient = q;
    rem_sign = s;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    div_rem = 1'b0;
    wait_result(tag);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_valid_clr"}, out_valid, 0);
  endtask

  vec_t vecs[8];

  initial begin
    exp_t        e;
    logic [29:0] rq;
    logic        rs;
    int          seen;

    vecs[0] = {30'h1000_0000, 1'b0, 24'h80_0000, 2'b00, 1'b0};
    vecs[1] = {30'h0800_0000, 1'b0, 24'h80_0000, 2'b11, 1'b0};
    vecs[2] = {30'h1000_0001, 1'b1, 24'h80_0000, 2'b00, 1'b0};
    vecs[3] = {30'h1000_0018, 1'b0, 24'h80_0001, 2'b00, 1'b0};
    vecs[4] = {30'h1000_0010, 1'b0, 24'h80_0000, 2'b00, 1'b0};
    vecs[5] = {30'h1000_0030, 1'b0, 24'h80_0002, 2'b00, 1'b0};
    vecs[6] = {30'h1FFF_FFF0, 1'b0, 24'h80_0000, 2'b01, 1'b0};
    vecs[7] = {30'h2000_0000, 1'b0, 24'hFF_FFFF, 2'b00, 1'b1};

    repeat (3) @(negedge clk);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_mant", mantissa, 0);
    check_eq("rst_exp", exp_adj, 0);
    check_eq("rst_rerr", range_err, 0);
    check_eq("rst_overrun", overrun, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].q, vecs[i].s, {vecs[i].m, vecs[i].e, vecs[i].r}, $sformatf("vec%0d", i));
      accept($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      rq = 30'($urandom_range(32'h0800_0001, 32'h2FFF_FFFF));
      rs = 1'($urandom_range(0, 1));
      issue(rq, rs, model(rq, rs), $sformatf("rnd%0d", i));
      accept($sformatf("rnd%0d", i));
    end
    check_eq("overrun_clean", overrun, 0);

    // Backpressure: a second strobe while the result is held is dropped.
    issue(30'h1000_0000, 1'b0, {24'h80_0000, 2'b00, 1'b0}, "bp");
    repeat (8) @(negedge clk);
    div_rem  = 1'b1;
    quotient = 30'h0800_0000;
    @(negedge clk);
    div_rem = 1'b0;
    check_eq("bp_overrun", overrun, 1);
    check_eq("bp_valid_held", out_valid, 1);
    check_eq("bp_mant_held", mantissa, 24'h80_0000);
    check_eq("bp_exp_held", exp_adj, 2'b00);
    repeat (2) @(negedge clk);
    check_eq("bp_valid_still", out_valid, 1);
    accept("bp");
    check_eq("bp_overrun_sticky", overrun, 1);

    // Asynchronous reset while the FSM is in NORM.
    div_rem  = 1'b1;
    quotient = 30'h1FFF_FFF0;
    rem_sign = 1'b0;
    @(negedge clk);
    div_rem = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_mant", mantissa, 0);
    check_eq("arst_exp", exp_adj, 0);
    check_eq("arst_overrun", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("arst_no_valid", seen, 0);
    issue(30'h1000_0018, 1'b0, {24'h80_0001, 2'b00, 1'b0}, "post_rst");

    // Back-to-back: accept and new strobe in the same HOLD cycle.
    out_ready = 1'b1;
    div_rem   = 1'b1;
    quotient  = 30'h0800_0000;
    rem_sign  = 1'b0;
    sb.push_back({24'h80_0000, 2'b11, 1'b0});
    @(negedge clk);
    out_ready = 1'b0;
    div_rem   = 1'b0;
    check_eq("b2b_valid_clr", out_valid, 0);
    wait_result("b2b");
    check_eq("b2b_overrun", overrun, 0);
    accept("b2b");
    check_eq("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
